// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream input and instruction-memory write port of the program loader.
//   byte_valid/byte_data  source -> loader, byte offered this cycle
//   byte_ready            loader -> source, byte accepted when valid && ready
//   wr_en/wr_addr/wr_data loader -> instruction memory, one-cycle write strobe per word
//   master: byte source / memory side; slave: the loader.
interface instr_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    modport master (output byte_valid, byte_data, input byte_ready, wr_en, wr_addr, wr_data);
    modport slave  (input byte_valid, byte_data, output byte_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: loads a length-prefixed little-endian byte stream into instruction memory,
// holding the core in reset until the whole image is written.
//   clk      system clock, rising edge
//   reset    asynchronous, active-low
//   start    one-cycle pulse, re-arms from DONE or ERROR
//   bus      instr_loader_if.slave: byte stream in, memory write port out
//   cpu_hold 1 keeps the core in reset
//   done     image loaded and accepted
//   error    load aborted (count overflow, or checksum mismatch)
// Optional: define INSTR_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module instr_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    instr_loader_if.slave bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    localparam int CW = $clog2(MAX_WORDS + 1);
    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA,
`ifdef INSTR_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERROR
    } state_t;
    state_t        state;
    logic [15:0]   len;
    logic [CW-1:0] word_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   shreg;
    logic          take;
    logic [15:0]   n_hdr;
    logic          last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif
    assign bus.byte_ready = state != DONE && state != ERROR;
    assign take = bus.byte_valid && bus.byte_ready;
    assign n_hdr = {bus.byte_data, len[7:0]};
    // word_cnt still holds the index of the word being completed
    assign last_word = 16'(word_cnt) + 16'd1 == len;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LEN_LO;
            len         <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= BASE_ADDR;
            bus.wr_data <= '0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                LEN_LO: if (take) begin
                    len[7:0] <= bus.byte_data;
                    state    <= LEN_HI;
                end
                LEN_HI: if (take) begin
                    len <= n_hdr;
                    if (32'(n_hdr) > MAX_WORDS) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else if (n_hdr == 16'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (take) begin
                    // bytes arrive LSB first, so shift in from the top
                    shreg    <= {bus.byte_data, shreg[23:8]};
                    byte_idx <= byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum     <= csum ^ bus.byte_data;
`endif
                    if (byte_idx == 2'd3) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= BASE_ADDR + (32'(word_cnt) << 2);
                        bus.wr_data <= {bus.byte_data, shreg};
                        word_cnt    <= word_cnt + 1'b1;
                        if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHECK: if (take) begin
                    if (bus.byte_data == csum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
`endif
                default: if (start) begin
                    state       <= LEN_LO;
                    cpu_hold    <= 1'b1;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    len         <= '0;
                    word_cnt    <= '0;
                    byte_idx    <= '0;
                    bus.wr_addr <= BASE_ADDR;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum        <= '0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven image loads plus reset/restart sequences for instr_loader.
module tb_instr_loader;
    localparam int MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    instr_loader_if bus();

    instr_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.slave),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      n;
        logic [3:0][31:0] w;
        bit               gaps;
        bit               bad_cs;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] stream [$];
    int         checks = 0;
    int         errors = 0;
    int         nwr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] n, input logic [31:0] w0, w1, w2, w3,
                                input bit gaps, input bit bad_cs);
        vec_t v;
        v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gaps = gaps;
        v.bad_cs = bad_cs;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input vec_t v, input int k);
        return k < 4 ? v.w[k] : {16'hC0DE, k[15:0]};
    endfunction

    function automatic int payload(input vec_t v);
        return int'(v.n) > MAXW ? 0 : int'(v.n);
    endfunction

    task automatic build(input vec_t v);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        stream.delete();
        stream.push_back(v.n[7:0]);
        stream.push_back(v.n[15:8]);
        if (int'(v.n) <= MAXW) begin
            for (int k = 0; k < int'(v.n); k++) begin
                w = word_of(v, k);
                for (int b = 0; b < 4; b++) begin
                    stream.push_back(w[8*b +: 8]);
                    x ^= w[8*b +: 8];
                end
            end
            if (CS) stream.push_back(v.bad_cs ? ~x : x);
        end
    endtask

    task automatic chk_we(input bit ew, input logic [31:0] ea, input logic [31:0] ed);
        chk("wr_en", 32'(bus.wr_en), 32'(ew));
        if (bus.wr_en) nwr++;
        if (ew) begin
            chk("wr_addr", bus.wr_addr, ea);
            chk("wr_data", bus.wr_data, ed);
        end
    endtask

    // Offers the stream byte by byte; a write is expected exactly one cycle after
    // the fourth byte of each payload word is accepted.
    task automatic send(input bit gaps, input int npay);
        int          i;
        int          cyc;
        int          limit;
        bit          ew;
        bit          v;
        logic [31:0] ea, ed;
        i = 0; cyc = 0; ew = 1'b0; ea = '0; ed = '0; nwr = 0;
        limit = 4 * stream.size() + 50;
        while (i < stream.size()) begin
            @(negedge clk);
            chk_we(ew, ea, ed);
            ew = 1'b0;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.byte_valid = v;
            bus.byte_data = stream[i];
            if (v && bus.byte_ready) begin
                if (i >= 2 && i < 2 + 4 * npay && (i - 2) % 4 == 3) begin
                    ew = 1'b1;
                    ea = BASE + 32'((i - 2) / 4 * 4);
                    ed = {stream[i], stream[i-1], stream[i-2], stream[i-3]};
                end
                i++;
            end
            cyc++;
            if (cyc > limit) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", i, stream.size());
                break;
            end
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        chk_we(ew, ea, ed);
        @(negedge clk);
        chk_we(1'b0, '0, '0);
    endtask

    task automatic final_state(input bit exp_err, input int npay);
        chk("done", 32'(done), 32'(!exp_err));
        chk("error", 32'(error), 32'(exp_err));
        chk("cpu_hold", 32'(cpu_hold), 32'(exp_err));
        chk("byte_ready_idle", 32'(bus.byte_ready), 32'd0);
        chk("write_count", 32'(nwr), 32'(npay));
    endtask

    // A byte offered together with start must not be consumed.
    task automatic rearm(input bit with_byte);
        @(negedge clk);
        start = 1'b1;
        bus.byte_valid = with_byte;
        bus.byte_data = 8'h05;
        chk("ready_during_start", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b0;
        chk("rearm_done", 32'(done), 32'd0);
        chk("rearm_error", 32'(error), 32'd0);
        chk("rearm_hold", 32'(cpu_hold), 32'd1);
        chk("rearm_ready", 32'(bus.byte_ready), 32'd1);
        chk("rearm_addr", bus.wr_addr, BASE);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_wr_addr"}, bus.wr_addr, BASE);
        chk({tag, "_wr_data"}, bus.wr_data, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd1);
    endtask

    initial begin
        bit   exp_err;
        vec_t v;
        vecs[0] = mk(16'd2,   32'h00100513, 32'h00A505B3, 32'h0, 32'h0, 1'b0, 1'b0);
        vecs[1] = mk(16'd2,   32'h00100513, 32'h00A505B3, 32'h0, 32'h0, 1'b1, 1'b0);
        vecs[2] = mk(16'd257, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        vecs[3] = mk(16'd0,   32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        vecs[4] = mk(16'd1,   32'h00000013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        vecs[5] = mk(16'd4,   32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h80000001, 1'b1, 1'b0);
        vecs[6] = mk(16'd256, 32'hCAFEF00D, 32'h00000000, 32'hA5A55A5A, 32'h0F0F0F0F, 1'b0, 1'b0);
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        #12;
        reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) rearm(t % 2 == 1);
            v = vecs[t];
            exp_err = int'(v.n) > MAXW || (CS && v.bad_cs);
            build(v);
            send(v.gaps, payload(v));
            final_state(exp_err, payload(v));
        end
        // Reset asserted mid-image while word 0 is being written, then a clean reload.
        rearm(1'b0);
        v = vecs[5];
        build(v);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_data = stream[i];
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("pre_reset_wr_en", 32'(bus.wr_en), 32'd1);
        chk("pre_reset_wr_data", bus.wr_data, 32'hDEADBEEF);
        #2 reset = 1'b0;
        #1;
        reset_values("async_reset");
        @(negedge clk);
        reset = 1'b1;
        send(1'b0, 4);
        final_state(1'b0, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
